keypad_scan_ctrl: RTL and testbench

- Sequences the 4x4 Pmod keypad: drives one column low at a time, samples the rows, and resolves one key per sweep.
- Debounces the key over whole sweeps, then emits a hex key code with a one-cycle valid pulse.
- Shifts accepted keys into a two-digit value for the SSD digit multiplexer.
- Sits between the keypad pins (kcol/krow) and the SSD driver in the keypad/SSD top level.

---
 rtl/keypad_scan_ctrl_if.sv | 27 ++
 rtl/keypad_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and decoded-key signals shared between the scan controller and its consumers.
interface keypad_scan_ctrl_if;
  logic [3:0] krow;
  logic [3:0] kcol;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [7:0] disp_val;

  modport master (
    input  krow,
    output kcol,
    output key_code,
    output key_valid,
    output key_held,
    output disp_val
  );

  modport slave (
    output krow,
    input  kcol,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  disp_val
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with sweep-level debounce, hex key decode and a
// two-digit shift register feeding the seven-segment display.
module keypad_scan_ctrl #(
  parameter int unsigned COL_CYCLES   = 125_000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  keypad_scan_ctrl_if.master        bus
);

  localparam int unsigned SLOT_W = $clog2(COL_CYCLES);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(COL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  logic [3:0]        row_s1;
  logic [3:0]        row_s2;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic              hit_vld;
  logic [1:0]        hit_col;
  logic [1:0]        hit_row;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        cand;

  logic              slot_last_c;
  logic              sweep_end_c;
  logic              row_any_c;
  logic [1:0]        row_low_c;
  logic              res_hit_c;
  logic [3:0]        res_key_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              accept_c;
  logic [3:0]        accept_key_c;

  // Key label for a {col, row} position.
  function automatic logic [3:0] key_map(input logic [3:0] col_row);
    logic [3:0] k;
    unique case (col_row)
      4'h0: k = 4'h1;
      4'h1: k = 4'h4;
      4'h2: k = 4'h7;
      4'h3: k = 4'h0;
      4'h4: k = 4'h2;
      4'h5: k = 4'h5;
      4'h6: k = 4'h8;
      4'h7: k = 4'hF;
      4'h8: k = 4'h3;
      4'h9: k = 4'h6;
      4'hA: k = 4'h9;
      4'hB: k = 4'hE;
      4'hC: k = 4'hA;
      4'hD: k = 4'hB;
      4'hE: k = 4'hC;
      4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  always_comb begin
    slot_last_c = (slot_cnt == SLOT_LAST);
    sweep_end_c = slot_last_c && (col_idx == 2'd3);
    row_any_c   = ~&row_s2;
    if (!row_s2[0])      row_low_c = 2'd0;
    else if (!row_s2[1]) row_low_c = 2'd1;
    else if (!row_s2[2]) row_low_c = 2'd2;
    else                 row_low_c = 2'd3;
    // An earlier column's hit always beats the column-3 sample closing the sweep.
    res_hit_c = hit_vld | row_any_c;
    res_key_c = hit_vld ? {hit_col, hit_row} : {col_idx, row_low_c};
  end

  always_comb begin
    cnt_inc_c    = cnt + CNT_ONE;
    accept_c     = 1'b0;
    accept_key_c = cand;
    if (sweep_end_c && res_hit_c) begin
      if (state == IDLE && CNT_MAX == CNT_ONE) begin
        accept_c     = 1'b1;
        accept_key_c = res_key_c;
      end else if (state == DEBOUNCE && res_key_c == cand && cnt_inc_c == CNT_MAX) begin
        accept_c = 1'b1;
      end
    end
  end

  // Row synchronizer, column sequencing and first-hit capture within a sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1   <= 4'hF;
      row_s2   <= 4'hF;
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      bus.kcol <= 4'b1110;
      hit_vld  <= 1'b0;
      hit_col  <= 2'd0;
      hit_row  <= 2'd0;
    end else begin
      row_s1 <= bus.krow;
      row_s2 <= row_s1;
      if (slot_last_c) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        bus.kcol <= ~(4'b0001 << (col_idx + 2'd1));
        if (sweep_end_c) begin
          hit_vld <= 1'b0;
        end else if (!hit_vld && row_any_c) begin
          hit_vld <= 1'b1;
          hit_col <= col_idx;
          hit_row <= row_low_c;
        end
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Debounce FSM, stepped once per completed sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cand          <= 4'h0;
      bus.key_code  <= 4'h0;
      bus.key_valid <= 1'b0;
      bus.key_held  <= 1'b0;
      bus.disp_val  <= 8'h00;
    end else begin
      bus.key_valid <= 1'b0;
      if (sweep_end_c) begin
        unique case (state)
          IDLE: begin
            if (res_hit_c) begin
              cand <= res_key_c;
              if (accept_c) begin
                state <= PRESSED;
                cnt   <= '0;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CNT_ONE;
              end
            end
          end
          DEBOUNCE: begin
            if (!res_hit_c) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (res_key_c == cand) begin
              if (accept_c) begin
                state <= PRESSED;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc_c;
              end
            end else begin
              cand <= res_key_c;
              cnt  <= CNT_ONE;
            end
          end
          PRESSED: begin
            // cnt counts consecutive non-matching sweeps toward release.
            if (res_hit_c && res_key_c == cand) begin
              cnt <= '0;
            end else if (cnt_inc_c == CNT_MAX) begin
              state        <= IDLE;
              cnt          <= '0;
              bus.key_held <= 1'b0;
            end else begin
              cnt <= cnt_inc_c;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
      if (accept_c) begin
        bus.key_code  <= key_map(accept_key_c);
        bus.key_valid <= 1'b1;
        bus.key_held  <= 1'b1;
        bus.disp_val  <= {bus.disp_val[3:0], key_map(accept_key_c)};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model drives the rows and a
// queue of expected key events is checked against every key_valid pulse.
module tb_keypad_scan_ctrl;

  localparam int unsigned COL_CYCLES   = 4;
  localparam int unsigned DEBOUNCE_CNT = 3;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] disp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  keypad_scan_ctrl_if kif();

  keypad_scan_ctrl #(
    .COL_CYCLES   (COL_CYCLES),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  logic        raw_mode;
  logic [3:0]  raw_rows;
  logic [15:0] pressed;
  logic [3:0]  mat_rows;

  // Matrix keypad: a pressed key at (col c, row r) pulls row r low while column c is driven low.
  always_comb begin
    mat_rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!kif.kcol[c] && pressed[c*4+r]) mat_rows[r] = 1'b0;
  end

  assign kif.krow = raw_mode ? raw_rows : mat_rows;

  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (kif.key_valid === 1'b1) begin
      pulses++;
      chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("key_code", 32'(kif.key_code), 32'(e.code));
        chk("disp_val", 32'(kif.disp_val), 32'(e.disp));
        chk("key_held_at_pulse", 32'(kif.key_held), 32'd1);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_kcol"},      32'(kif.kcol),      32'h0000_000E);
    chk({tag, "_key_code"},  32'(kif.key_code),  32'd0);
    chk({tag, "_key_valid"}, 32'(kif.key_valid), 32'd0);
    chk({tag, "_key_held"},  32'(kif.key_held),  32'd0);
    chk({tag, "_disp_val"},  32'(kif.disp_val),  32'd0);
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int start;
    int n;
    start = pulses;
    n     = 0;
    while (pulses == start && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(pulses - start), 32'd1);
  endtask

  task automatic wait_release(input string tag, input int budget);
    int n;
    n = 0;
    while (kif.key_held !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(kif.key_held), 32'd0);
  endtask

  initial begin
    logic [3:0] ek;
    int         p0;

    raw_mode = 1'b1;
    raw_rows = 4'hF;
    pressed  = 16'h0000;
    rst_n    = 1'b0;

    // 1: reset, then idle scanning with no key.
    do_reset(3);
    chk_reset_outputs("t1_reset");
    for (int i = 0; i < 100; i++) begin
      tick();
      ek = 4'hF;
      ek[(cyc / 4) % 4] = 1'b0;
      chk("t1_kcol", 32'(kif.kcol), 32'(ek));
    end
    chk("t1_no_pulse",  32'(pulses),       32'd0);
    chk("t1_key_held",  32'(kif.key_held), 32'd0);
    chk("t1_key_code",  32'(kif.key_code), 32'd0);
    chk("t1_disp_val",  32'(kif.disp_val), 32'd0);

    // 2: row 2 low in every column -> column 0 wins -> key 7.
    raw_rows = 4'b1011;
    exp_q.push_back('{code: 4'h7, disp: 8'h07});
    wait_pulse("t2_pulse", 100);
    repeat (48) tick();
    chk("t2_key_held", 32'(kif.key_held), 32'd1);
    chk("t2_key_code", 32'(kif.key_code), 32'h7);

    // 3: release, then row 3 in column 0 -> key 0, previous digit shifts up.
    raw_rows = 4'hF;
    wait_release("t3_release", 80);
    chk("t3_code_hold", 32'(kif.key_code), 32'h7);
    chk("t3_disp_hold", 32'(kif.disp_val), 32'h07);
    raw_rows = 4'b0111;
    exp_q.push_back('{code: 4'h0, disp: 8'h70});
    wait_pulse("t3_pulse", 100);

    // 4: bouncing row 0 (10 low / 10 high) never yields three matching sweeps.
    raw_rows = 4'hF;
    wait_release("t4_pre_release", 80);
    while (cyc % 4 != 2) tick();
    p0 = pulses;
    for (int k = 0; k < 8; k++) begin
      raw_rows = 4'b1110;
      repeat (10) tick();
      raw_rows = 4'hF;
      repeat (10) tick();
    end
    chk("t4_bounce_no_pulse", 32'(pulses - p0), 32'd0);
    exp_q.push_back('{code: 4'h1, disp: 8'h01});
    raw_rows = 4'b1110;
    wait_pulse("t4_pulse", 100);

    // 5: key B via the matrix; a brief extra press in column 1 must not disturb the held key.
    raw_rows = 4'hF;
    wait_release("t5_pre_release", 80);
    raw_mode    = 1'b0;
    pressed[13] = 1'b1;
    exp_q.push_back('{code: 4'hB, disp: 8'h1B});
    wait_pulse("t5_pulse", 100);
    p0 = pulses;
    repeat (20) tick();
    pressed[4] = 1'b1;
    repeat (20) tick();
    chk("t5_held_during_extra", 32'(kif.key_held), 32'd1);
    pressed[4] = 1'b0;
    repeat (48) tick();
    chk("t5_held_after_extra", 32'(kif.key_held), 32'd1);
    chk("t5_no_new_pulse",     32'(pulses - p0),   32'd0);
    chk("t5_code_hold",        32'(kif.key_code),  32'hB);
    pressed = 16'h0000;
    wait_release("t5_release", 80);

    // 6: reset with the debounce count at 2 discards the press; acceptance restarts from scratch.
    raw_mode = 1'b1;
    raw_rows = 4'hF;
    while (cyc % 16 != 0) tick();
    raw_rows = 4'b1110;
    p0 = pulses;
    repeat (34) tick();
    do_reset(1);
    chk_reset_outputs("t6_reset");
    chk("t6_no_pulse_before_reset", 32'(pulses - p0), 32'd0);
    exp_q.push_back('{code: 4'h1, disp: 8'h01});
    wait_pulse("t6_pulse", 80);
    chk("t6_latency", 32'(cyc), 32'd48);

    repeat (16) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
